// File: rtl/reg_bus_master.sv
// reg_bus_master
//   Bus initiator for the FIFO configuration/status register file. Accepts one
//   command at a time over a valid/ready handshake and runs a single write,
//   a single read, or a repeated-read poll on the shared tri-state register
//   bus. Exactly one response pulse is produced per accepted command.
//
// Build option:
//   REG_BUS_MASTER_POLL_EN  - when defined, the poll op (2'b10), the CHECK
//                             state, the attempt counter and the mask compare
//                             are compiled in. When undefined, op 2'b10 is
//                             rejected like the reserved op.
//
// Parameters:
//   POLL_TIMEOUT  maximum read attempts per poll command (>= 1)
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready command handshake (ready only while idle)
//   i_cmd_op                00 write, 01 read, 10 poll, 11 reserved
//   i_cmd_addr              register address, legal 0..4
//   i_cmd_wdata             write data, or expected value for poll
//   i_cmd_mask              poll compare mask
//   o_rsp_valid             one-cycle response pulse
//   o_rsp_rdata             read data / last polled value / zero for write
//   o_rsp_err               bad op, bad address or poll timeout
//   o_wr_en, o_rd_en        registered bus strobes, never both high
//   o_addr                  registered bus address
//   io_data                 bus data, driven only during the write strobe

module reg_bus_master #(
    parameter int unsigned POLL_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [1:0]  i_cmd_op,
    input  logic [2:0]  i_cmd_addr,
    input  logic [15:0] i_cmd_wdata,
    input  logic [15:0] i_cmd_mask,
    output logic        o_rsp_valid,
    output logic [15:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_wr_en,
    output logic        o_rd_en,
    output logic [2:0]  o_addr,
    inout  wire  [15:0] io_data
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
`ifdef REG_BUS_MASTER_POLL_EN
        CHECK,
`endif
        RESP
    } state_t;

    state_t      state;
    logic [15:0] wdata_q;   // write data, or the poll expected value
    logic        drive_q;   // master owns io_data (write strobe cycle only)
    logic        cmd_bad;

`ifdef REG_BUS_MASTER_POLL_EN
    localparam int unsigned CNT_W = $clog2(POLL_TIMEOUT + 1);

    logic             poll_q;
    logic [15:0]      mask_q;
    logic [15:0]      rdata_q;
    logic [CNT_W-1:0] cnt_q;
    logic             poll_match;

    assign poll_match = ((rdata_q & mask_q) == (wdata_q & mask_q));
`else
    localparam int unsigned UNUSED_POLL_TIMEOUT = POLL_TIMEOUT;
    logic unused_mask;
    assign unused_mask = ^i_cmd_mask;
`endif

    always_comb begin
        cmd_bad = (i_cmd_addr > 3'd4);
`ifdef REG_BUS_MASTER_POLL_EN
        if (i_cmd_op == 2'b11) cmd_bad = 1'b1;
`else
        if (i_cmd_op[1]) cmd_bad = 1'b1;
`endif
    end

    assign io_data = drive_q ? wdata_q : 'z;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            wdata_q     <= '0;
            drive_q     <= 1'b0;
            o_cmd_ready <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
            o_wr_en     <= 1'b0;
            o_rd_en     <= 1'b0;
            o_addr      <= '0;
`ifdef REG_BUS_MASTER_POLL_EN
            poll_q      <= 1'b0;
            mask_q      <= '0;
            rdata_q     <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    o_cmd_ready <= 1'b1;
                    if (i_cmd_valid && o_cmd_ready) begin
                        o_cmd_ready <= 1'b0;
                        wdata_q     <= i_cmd_wdata;
`ifdef REG_BUS_MASTER_POLL_EN
                        poll_q      <= (i_cmd_op == 2'b10);
                        mask_q      <= i_cmd_mask;
                        cnt_q       <= '0;
`endif
                        if (cmd_bad) begin
                            // Rejected commands skip the bus entirely.
                            state       <= RESP;
                            o_rsp_valid <= 1'b1;
                            o_rsp_rdata <= '0;
                            o_rsp_err   <= 1'b1;
                        end else if (i_cmd_op == 2'b00) begin
                            state   <= WRITE;
                            o_addr  <= i_cmd_addr;
                            o_wr_en <= 1'b1;
                            drive_q <= 1'b1;
                        end else begin
                            state   <= READ;
                            o_addr  <= i_cmd_addr;
                            o_rd_en <= 1'b1;
                        end
                    end
                end

                WRITE: begin
                    o_wr_en     <= 1'b0;
                    drive_q     <= 1'b0;
                    state       <= RESP;
                    o_rsp_valid <= 1'b1;
                    o_rsp_rdata <= '0;
                    o_rsp_err   <= 1'b0;
                end

                READ: begin
                    o_rd_en <= 1'b0;
`ifdef REG_BUS_MASTER_POLL_EN
                    rdata_q <= io_data;
                    if (poll_q) begin
                        state <= CHECK;
                    end else begin
                        state       <= RESP;
                        o_rsp_valid <= 1'b1;
                        o_rsp_rdata <= io_data;
                        o_rsp_err   <= 1'b0;
                    end
`else
                    state       <= RESP;
                    o_rsp_valid <= 1'b1;
                    o_rsp_rdata <= io_data;
                    o_rsp_err   <= 1'b0;
`endif
                end

`ifdef REG_BUS_MASTER_POLL_EN
                CHECK: begin
                    if (poll_match) begin
                        state       <= RESP;
                        o_rsp_valid <= 1'b1;
                        o_rsp_rdata <= rdata_q;
                        o_rsp_err   <= 1'b0;
                    end else if (cnt_q == CNT_W'(POLL_TIMEOUT - 1)) begin
                        // This failed attempt was the last one allowed.
                        state       <= RESP;
                        o_rsp_valid <= 1'b1;
                        o_rsp_rdata <= rdata_q;
                        o_rsp_err   <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                        state   <= READ;
                        o_rd_en <= 1'b1;
                    end
                end
`endif

                RESP: begin
                    o_rsp_valid <= 1'b0;
                    o_rsp_rdata <= '0;
                    o_rsp_err   <= 1'b0;
                    o_cmd_ready <= 1'b1;
                    state       <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bus_master.sv
module tb_reg_bus_master;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_cmd_valid = 1'b0;
    logic        o_cmd_ready;
    logic [1:0]  i_cmd_op = '0;
    logic [2:0]  i_cmd_addr = '0;
    logic [15:0] i_cmd_wdata = '0;
    logic [15:0] i_cmd_mask = '0;
    logic        o_rsp_valid;
    logic [15:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic        o_wr_en;
    logic        o_rd_en;
    logic [2:0]  o_addr;
    wire  [15:0] io_data;

    always #5 i_clk = ~i_clk;

    reg_bus_master #(.POLL_TIMEOUT(4)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd_op    (i_cmd_op),
        .i_cmd_addr  (i_cmd_addr),
        .i_cmd_wdata (i_cmd_wdata),
        .i_cmd_mask  (i_cmd_mask),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_rdata (o_rsp_rdata),
        .o_rsp_err   (o_rsp_err),
        .o_wr_en     (o_wr_en),
        .o_rd_en     (o_rd_en),
        .o_addr      (o_addr),
        .io_data     (io_data)
    );

    int unsigned total = 0;
    int unsigned bad = 0;

    // Register file model
    int unsigned wr_pulses = 0;
    int unsigned rd_pulses = 0;
    int unsigned rsp_pulses = 0;
    int unsigned both_hi = 0;
    int unsigned base_rd = 0;
    logic [15:0] margin_q = '0;
    logic [2:0]  wr_addr_q = '0;
    logic [15:0] wr_data_q = '0;
    logic [15:0] rf_val;

    always_comb begin
        rf_val = '0;
        case (o_addr)
            3'd1: rf_val = margin_q;
            3'd2: rf_val = 16'h0010 + 16'(rd_pulses - base_rd);
            3'd3: rf_val = 16'h0004;   // full=1, near_full=0, overflow=0
            3'd4: rf_val = ((rd_pulses - base_rd) >= 3) ? 16'h0004 : 16'h0001;
            default: ;
        endcase
    end

    assign io_data = o_rd_en ? rf_val : 'z;

    always @(posedge i_clk) begin
        if (o_wr_en) begin
            wr_pulses <= wr_pulses + 1;
            wr_addr_q <= o_addr;
            wr_data_q <= io_data;
            if (o_addr == 3'd1) margin_q <= io_data;
        end
        if (o_rd_en) rd_pulses <= rd_pulses + 1;
        if (o_rsp_valid) rsp_pulses <= rsp_pulses + 1;
        if (o_wr_en && o_rd_en) both_hi <= both_hi + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issues one command and measures accept-to-response latency in cycles.
    task automatic issue(input logic [1:0] op, input logic [2:0] addr,
                         input logic [15:0] wd, input logic [15:0] mask,
                         output int lat, output logic [15:0] rd, output logic err);
        int waited = 0;
        lat = 99;
        rd  = 'x;
        err = 1'bx;
        @(negedge i_clk);
        while (!o_cmd_ready && waited < 20) begin
            @(negedge i_clk);
            waited++;
        end
        check("ready_wait", {31'd0, o_cmd_ready}, 32'd1);
        i_cmd_valid = 1'b1;
        i_cmd_op    = op;
        i_cmd_addr  = addr;
        i_cmd_wdata = wd;
        i_cmd_mask  = mask;
        @(posedge i_clk);
        #1 i_cmd_valid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge i_clk);
            if (o_rsp_valid) begin
                lat = n;
                rd  = o_rsp_rdata;
                err = o_rsp_err;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        logic [15:0] rd;
        logic err;
        int unsigned w0, r0, s0;

        // Reset state
        repeat (2) @(negedge i_clk);
        check("rst_ready", {31'd0, o_cmd_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        check("rst_rdata", {16'd0, o_rsp_rdata}, 32'd0);
        check("rst_err", {31'd0, o_rsp_err}, 32'd0);
        check("rst_wr_en", {31'd0, o_wr_en}, 32'd0);
        check("rst_rd_en", {31'd0, o_rd_en}, 32'd0);
        check("rst_addr", {29'd0, o_addr}, 32'd0);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        check("ready_after_rst", {31'd0, o_cmd_ready}, 32'd1);

        // Write addr 1 <= 9
        w0 = wr_pulses; r0 = rd_pulses;
        issue(2'b00, 3'd1, 16'h0009, 16'h0000, lat, rd, err);
        check("wr_lat", 32'(lat), 32'd2);
        check("wr_rdata", {16'd0, rd}, 32'd0);
        check("wr_err", {31'd0, err}, 32'd0);
        check("wr_pulses", wr_pulses - w0, 32'd1);
        check("wr_no_rd", rd_pulses - r0, 32'd0);
        check("wr_bus_addr", {29'd0, wr_addr_q}, 32'd1);
        check("wr_bus_data", {16'd0, wr_data_q}, 32'h0009);
        check("margin_reg", {16'd0, margin_q}, 32'h0009);
        @(negedge i_clk);
        check("ready_cycle3", {31'd0, o_cmd_ready}, 32'd1);

        // Read status addr 3
        w0 = wr_pulses; r0 = rd_pulses;
        issue(2'b01, 3'd3, 16'hFFFF, 16'h0000, lat, rd, err);
        check("rd3_lat", 32'(lat), 32'd2);
        check("rd3_rdata", {16'd0, rd}, 32'h0004);
        check("rd3_err", {31'd0, err}, 32'd0);
        check("rd3_pulses", rd_pulses - r0, 32'd1);
        check("rd3_no_wr", wr_pulses - w0, 32'd0);

        // Read back margin register
        issue(2'b01, 3'd1, 16'hA5A5, 16'h0000, lat, rd, err);
        check("rd1_rdata", {16'd0, rd}, 32'h0009);

        // Poll success: value matches on the 4th read
        base_rd = rd_pulses; r0 = rd_pulses;
        issue(2'b10, 3'd4, 16'h0004, 16'h0004, lat, rd, err);
`ifdef REG_BUS_MASTER_POLL_EN
        check("poll_ok_lat", 32'(lat), 32'd9);
        check("poll_ok_rdata", {16'd0, rd}, 32'h0004);
        check("poll_ok_err", {31'd0, err}, 32'd0);
        check("poll_ok_pulses", rd_pulses - r0, 32'd4);
`else
        check("poll_off_lat", 32'(lat), 32'd1);
        check("poll_off_err", {31'd0, err}, 32'd1);
        check("poll_off_rdata", {16'd0, rd}, 32'd0);
        check("poll_off_pulses", rd_pulses - r0, 32'd0);
`endif

        // Poll timeout: addr 2 never has bit 15 set; reads 0x10..0x13
        base_rd = rd_pulses; r0 = rd_pulses;
        issue(2'b10, 3'd2, 16'h8000, 16'h8000, lat, rd, err);
`ifdef REG_BUS_MASTER_POLL_EN
        check("poll_to_lat", 32'(lat), 32'd9);
        check("poll_to_err", {31'd0, err}, 32'd1);
        check("poll_to_rdata", {16'd0, rd}, 32'h0013);
        check("poll_to_pulses", rd_pulses - r0, 32'd4);
`else
        check("poll_off2_err", {31'd0, err}, 32'd1);
        check("poll_off2_pulses", rd_pulses - r0, 32'd0);
`endif

        // Bad commands
        w0 = wr_pulses; r0 = rd_pulses;
        issue(2'b00, 3'd6, 16'h1234, 16'h0000, lat, rd, err);
        check("bad_addr_lat", 32'(lat), 32'd1);
        check("bad_addr_err", {31'd0, err}, 32'd1);
        issue(2'b11, 3'd2, 16'h1234, 16'h0000, lat, rd, err);
        check("bad_op_lat", 32'(lat), 32'd1);
        check("bad_op_err", {31'd0, err}, 32'd1);
        issue(2'b01, 3'd5, 16'h0000, 16'h0000, lat, rd, err);
        check("bad_rd5_err", {31'd0, err}, 32'd1);
        @(negedge i_clk);
        check("bad_ready_cycle2", {31'd0, o_cmd_ready}, 32'd1);
        check("bad_no_wr", wr_pulses - w0, 32'd0);
        check("bad_no_rd", rd_pulses - r0, 32'd0);

        // Reset during a transaction (poll when built, else read)
        base_rd = rd_pulses;
        @(negedge i_clk);
        i_cmd_valid = 1'b1;
`ifdef REG_BUS_MASTER_POLL_EN
        i_cmd_op = 2'b10; i_cmd_addr = 3'd2; i_cmd_wdata = 16'h8000; i_cmd_mask = 16'h8000;
`else
        i_cmd_op = 2'b01; i_cmd_addr = 3'd3; i_cmd_wdata = 16'h0000; i_cmd_mask = 16'h0000;
`endif
        @(posedge i_clk);
        #1 i_cmd_valid = 1'b0;
        @(negedge i_clk);
        check("mid_rd_strobe", {31'd0, o_rd_en}, 32'd1);
        s0 = rsp_pulses;
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_rd_en", {31'd0, o_rd_en}, 32'd0);
        check("mid_rst_wr_en", {31'd0, o_wr_en}, 32'd0);
        check("mid_rst_ready", {31'd0, o_cmd_ready}, 32'd0);
        check("mid_rst_valid", {31'd0, o_rsp_valid}, 32'd0);
        check("mid_rst_addr", {29'd0, o_addr}, 32'd0);
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (12) @(negedge i_clk);
        check("mid_rst_no_rsp", rsp_pulses - s0, 32'd0);

        issue(2'b01, 3'd3, 16'h0000, 16'h0000, lat, rd, err);
        check("post_rst_lat", 32'(lat), 32'd2);
        check("post_rst_rdata", {16'd0, rd}, 32'h0004);
        check("post_rst_err", {31'd0, err}, 32'd0);

        check("never_both_strobes", both_hi, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reg_bus_master.md
# reg_bus_master

Bus initiator for the FIFO configuration/status register file. It accepts single commands from a host or sequencer over a valid/ready handshake and runs write, read or poll transactions on the shared 16-bit tri-state register bus (`o_wr_en`/`o_rd_en`/`o_addr`/`io_data`). It returns one response per command. It sits in the same clock domain as the register file and drives that file's bus inputs.

## Interface
- `POLL_TIMEOUT`, default 255: maximum read attempts per poll command. Must be at least 1. The counter width is `$clog2(POLL_TIMEOUT+1)`.
- `i_clk`  in  1  clock. Single domain.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_cmd_valid`  in  1  command present.
- `o_cmd_ready`  out  1  master can accept a command. High only in IDLE.
- `i_cmd_op`  in  2  operation: 00 write, 01 read, 10 poll, 11 reserved.
- `i_cmd_addr`  in  3  register address. Valid range is 0..4.
- `i_cmd_wdata`  in  16  write data, or expected value for poll.
- `i_cmd_mask`  in  16  poll compare mask. Ignored for other ops.
- `o_rsp_valid`  out  1  one-cycle response pulse.
- `o_rsp_rdata`  out  16  read data. For poll, the last value read. Zero for write.
- `o_rsp_err`  out  1  error (bad op, bad address, or poll timeout). Qualified by `o_rsp_valid`.
- `o_wr_en`  out  1  bus write strobe.
- `o_rd_en`  out  1  bus read strobe.
- `o_addr`  out  3  bus address.
- `io_data`  inout  16  bus data. Driven by the master only in WRITE. High-Z otherwise.

## Operation
- States:
  - IDLE: `o_cmd_ready`=1.
  - WRITE
  - READ
  - CHECK (poll only)
  - RESP: `o_rsp_valid`=1.
- IDLE transitions:
  - On `i_cmd_valid && o_cmd_ready`, the master captures op, addr, wdata and mask.
  - op=00 with addr≤4 goes to WRITE.
  - op=01 or op=10 with addr≤4 goes to READ.
  - Any other command (reserved op, or addr 5..7) goes straight to RESP with err=1. No bus activity occurs.
- WRITE: `o_wr_en`=1, `o_addr`=addr, `io_data`=wdata for exactly one cycle, then RESP.
- READ:
  - `o_rd_en`=1 and `o_addr`=addr for one cycle. The master releases `io_data`.
  - `io_data` is registered into the rdata register at the closing edge.
  - A read goes to RESP. A poll goes to CHECK.
- CHECK (poll):
  - Match when `(rdata & mask) == (wdata & mask)`. On match, go to RESP with err=0.
  - Otherwise increment the attempt counter.
  - If the count reaches `POLL_TIMEOUT`, go to RESP with err=1.
  - Otherwise go back to READ.
- RESP: outputs rdata (zero for write) and err for one cycle, then returns to IDLE.
- There is no response backpressure. The consumer must accept the `o_rsp_valid` pulse.
- Bus outputs are registered. `o_wr_en` and `o_rd_en` are never both high. `io_data` is never driven while `o_rd_en`=1.
- Reset value of every output:
  - `o_cmd_ready`=0 during reset, 1 after release.
  - `o_rsp_valid`=0, `o_rsp_rdata`=0, `o_rsp_err`=0.
  - `o_wr_en`=0, `o_rd_en`=0, `o_addr`=0.
  - `io_data`=Z.
- Reset mid-transaction: the command is dropped, no response is issued, and the attempt counter clears.

## Timing
- Cycle 0 is the accept edge.
- Write and read: bus strobe in cycle 1, `o_rsp_valid` in cycle 2, `o_cmd_ready` high again in cycle 3.
- Error command: `o_rsp_valid` in cycle 1, `o_cmd_ready` in cycle 2.
- Poll: each attempt takes 2 cycles (READ+CHECK). The response comes 1 cycle after the deciding CHECK. Worst case is 2·`POLL_TIMEOUT`+1 cycles after accept.
- The RESP and IDLE cycles between any two bus strobes act as bus turnaround. Back-to-back strobes never happen.
- A command held on `i_cmd_valid` while `o_cmd_ready`=0 is not captured. The host must keep it stable until accepted.

## Configuration
- `REG_BUS_MASTER_POLL_EN` defined: poll op 10, the CHECK state, the attempt counter and the mask compare are compiled in.
- Not defined: op 10 is treated as reserved and returns RESP with err=1 and no bus activity. `i_cmd_mask` and `POLL_TIMEOUT` are unused. The CHECK state and counter logic are absent.

## Test plan
- Write: addr=1, wdata=0x0009.
  - `o_wr_en`=1 for exactly one cycle with `o_addr`=1 and `io_data`=0x0009.
  - Register file near-full margin becomes 9.
  - `o_rsp_valid` one cycle later with err=0 and rdata=0.
- Read: addr=3 with full=1, near_full=0, overflow=0 on the register file.
  - `o_rd_en` for one cycle.
  - Response rdata=0x0004, err=0.
  - `io_data` is never driven by the master during the strobe.
- Poll success: addr=4, mask=0x0004, wdata=0x0004; empty rises after 3 attempts.
  - Response err=0, rdata=0x0004.
  - Exactly 4 `o_rd_en` pulses.
- Poll timeout: `POLL_TIMEOUT`=4, with the condition never met.
  - Exactly 4 `o_rd_en` pulses.
  - Response err=1, rdata equal to the last value read.
- Bad commands: write to addr=6, or op=11.
  - No `o_wr_en`/`o_rd_en`.
  - Response one cycle after accept with err=1.
- Reset asserted during a poll:
  - All outputs take their reset values immediately and `io_data`=Z.
  - No response is issued.
  - After release, a new read completes normally.
